// File: rtl/acorn_pkg.sv
// Shared constants, tap positions, FSM encoding and boolean helpers for the
// ACORN-128 state datapath.
package acorn_pkg;

  // Algorithm-fixed sizes
  localparam int unsigned STATE_W    = 293;
  localparam int unsigned INIT_STEPS = 1792;
  localparam int unsigned CNT_W      = 12;

  // Counter values presented upstream during initialization
  localparam logic [CNT_W-1:0] CNT_FIRST = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(INIT_STEPS);

  // State tap positions used by the step function
  localparam int unsigned TAP_0   = 0;
  localparam int unsigned TAP_12  = 12;
  localparam int unsigned TAP_23  = 23;
  localparam int unsigned TAP_61  = 61;
  localparam int unsigned TAP_66  = 66;
  localparam int unsigned TAP_107 = 107;
  localparam int unsigned TAP_111 = 111;
  localparam int unsigned TAP_154 = 154;
  localparam int unsigned TAP_160 = 160;
  localparam int unsigned TAP_193 = 193;
  localparam int unsigned TAP_196 = 196;
  localparam int unsigned TAP_230 = 230;
  localparam int unsigned TAP_235 = 235;
  localparam int unsigned TAP_244 = 244;
  localparam int unsigned TAP_289 = 289;

  // Sequencer states
  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StInit  = 2'd1,
    StFlush = 2'd2,
    StReady = 2'd3
  } acorn_fsm_e;

  // Majority of three bits
  function automatic logic maj(input logic x, input logic y, input logic z);
    return (x & y) ^ (x & z) ^ (y & z);
  endfunction

  // Choose: x selects y, otherwise z
  function automatic logic ch(input logic x, input logic y, input logic z);
    return (x & y) ^ (~x & z);
  endfunction

endpackage

// File: rtl/acorn_step_fn.sv
// One ACORN-128 state step: LFSR feedback updates, keystream bit and
// nonlinear shift-in. Purely combinational so it can be reused by the
// tag/finalization logic.
module acorn_step_fn
  import acorn_pkg::*;
(
  input  logic [STATE_W-1:0] state_i,
  input  logic               m_i,
  input  logic               ca_i,
  input  logic               cb_i,
  output logic [STATE_W-1:0] next_state_o,
  output logic               ks_o
);

  logic [STATE_W-1:0] s;
  logic               ks;
  logic               f;

  // Apply the six feedback updates in order, then derive ks, f and shift
  always_comb begin
    s = state_i;
    s[TAP_289] = s[TAP_289] ^ s[TAP_235] ^ s[TAP_230];
    s[TAP_230] = s[TAP_230] ^ s[TAP_196] ^ s[TAP_193];
    s[TAP_193] = s[TAP_193] ^ s[TAP_160] ^ s[TAP_154];
    s[TAP_154] = s[TAP_154] ^ s[TAP_111] ^ s[TAP_107];
    s[TAP_107] = s[TAP_107] ^ s[TAP_66]  ^ s[TAP_61];
    s[TAP_61]  = s[TAP_61]  ^ s[TAP_23]  ^ s[TAP_0];

    ks = s[TAP_12] ^ s[TAP_154]
       ^ maj(s[TAP_235], s[TAP_61], s[TAP_193])
       ^ ch(s[TAP_230], s[TAP_111], s[TAP_66]);

    f = s[TAP_0] ^ ~s[TAP_107]
      ^ maj(s[TAP_244], s[TAP_23], s[TAP_160])
      ^ (ca_i & s[TAP_196])
      ^ (cb_i & ks)
      ^ m_i;

    next_state_o = {f, s[STATE_W-1:1]};
    ks_o         = ks;
  end

endmodule

// File: rtl/acorn_state_core.sv
// ACORN-128 state holder and initialization sequencer. Drives the upstream
// bit generator's step counter, runs the 1792 init steps with the generator's
// registered bits, then steps on external request and emits keystream.
module acorn_state_core
  import acorn_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  output logic [CNT_W-1:0]   count_out,
  input  logic               mbit_in,
  input  logic               ca_in,
  input  logic               cb_in,
  input  logic               step_valid,
  input  logic               m_in,
  input  logic               ca_ext,
  input  logic               cb_ext,
  output logic               busy,
  output logic               init_done,
  output logic               ks_out,
  output logic               ks_valid,
  output logic [STATE_W-1:0] state_out
);

  acorn_fsm_e         fsm_q;
  logic [CNT_W-1:0]   cnt_q;
  // Upstream data lags its count by one cycle, so steps trail the counter
  logic               issue_q;
  logic [STATE_W-1:0] state_q;
  logic               init_done_q;
  logic               ks_q;
  logic               ks_valid_q;

  logic               step_m;
  logic               step_ca;
  logic               step_cb;
  logic [STATE_W-1:0] step_next;
  logic               step_ks;

  // Select step inputs: upstream generator during init, external otherwise
  always_comb begin
    step_m  = mbit_in;
    step_ca = ca_in;
    step_cb = cb_in;
    if (fsm_q == StReady) begin
      step_m  = m_in;
      step_ca = ca_ext;
      step_cb = cb_ext;
    end
  end

  acorn_step_fn u_step_fn (
    .state_i      (state_q),
    .m_i          (step_m),
    .ca_i         (step_ca),
    .cb_i         (step_cb),
    .next_state_o (step_next),
    .ks_o         (step_ks)
  );

  // Sequencer, counter, pending-step flag, state register and keystream regs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fsm_q       <= StIdle;
      cnt_q       <= '0;
      issue_q     <= 1'b0;
      state_q     <= '0;
      init_done_q <= 1'b0;
      ks_q        <= 1'b0;
      ks_valid_q  <= 1'b0;
    end else begin
      init_done_q <= 1'b0;
      ks_valid_q  <= 1'b0;

      // Init step for the count presented one cycle earlier
      if (issue_q) begin
        state_q <= step_next;
      end

      unique case (fsm_q)
        StIdle: begin
          if (start) begin
            fsm_q   <= StInit;
            state_q <= '0;
            cnt_q   <= CNT_FIRST;
          end
        end
        StInit: begin
          issue_q <= 1'b1;
          if (cnt_q == CNT_LAST) begin
            fsm_q <= StFlush;
            cnt_q <= '0;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        StFlush: begin
          // Last init step executes this cycle via issue_q
          issue_q     <= 1'b0;
          fsm_q       <= StReady;
          init_done_q <= 1'b1;
        end
        StReady: begin
          if (start) begin
            fsm_q   <= StInit;
            state_q <= '0;
            cnt_q   <= CNT_FIRST;
          end else if (step_valid) begin
            state_q    <= step_next;
            ks_q       <= step_ks;
            ks_valid_q <= 1'b1;
          end
        end
        default: begin
          fsm_q <= StIdle;
        end
      endcase
    end
  end

  assign count_out = (fsm_q == StInit) ? cnt_q : '0;
  assign busy      = (fsm_q == StInit) || (fsm_q == StFlush);
  assign init_done = init_done_q;
  assign ks_out    = ks_q;
  assign ks_valid  = ks_valid_q;
  assign state_out = state_q;

endmodule
